sram_async_ctrl: RTL and testbench
==================================

// Module: sram_async_ctrl
// PURPOSE
//  Single-port controller for a 128K x 8 asynchronous SRAM (CS1_/CS2/OE_/WE_ style).
//  Accepts one read or write request per handshake from the user side.
//  Sequences the SRAM strobes with setup, access and hold timing in whole clock cycles.
//  Returns read data and a busy flag. Sits between on-chip logic and the external SRAM pins.
// PARAMETERS
//  ADDR_W      17  address width (128K words)
//  DATA_W      8   data width
//  WAIT_CYCLES 2   cycles the OE_/WE_ strobe is held low (>=1); sized for SRAM tAA/tWP at clk rate
// PORTS
//  clk       in    1       system clock, all logic on rising edge
//  reset     in    1       asynchronous, active-high reset
//  addr      in    ADDR_W  request address, sampled at accept
//  data_in   in    DATA_W  write data, sampled at accept
//  write     in    1       1=write, 0=read, sampled at accept
//  ena       in    1       request strobe, level; sampled only when idle
//  busy      out   1       high while an access is in progress
//  data_out  out   DATA_W  last read data; updated at read completion
//  ram_addr  out   ADDR_W  SRAM address pins
//  ram_dq    inout DATA_W  SRAM data bus; Z unless writing
//  ram_we_   out   1       SRAM write enable, active low
//  ram_oe_   out   1       SRAM output enable, active low
//  ram_cs1_  out   1       SRAM chip select 1, active low
//  ram_cs2   out   1       SRAM chip select 2, active high
// BEHAVIOUR
//  Reset (async, immediate, also mid-access): state=IDLE, busy=0, data_out=0, ram_addr=0,
//   ram_we_=1, ram_oe_=1, ram_cs1_=1, ram_cs2=0, ram_dq=Z. No partial write continues.
//  All outputs are registered; dq output-enable is a registered flag.
//  FSM IDLE -> SETUP -> ACCESS (WAIT_CYCLES) -> HOLD -> IDLE.
//  IDLE: busy=0, strobes inactive. Rising edge with ena=1: latch addr/data_in/write,
//   go SETUP. busy=1 is visible right after that edge (1-cycle latency).
//  SETUP (1 cycle): ram_addr=latched addr, cs1_=0, cs2=1. If write: drive ram_dq.
//  ACCESS (WAIT_CYCLES cycles): read -> oe_=0; write -> we_=0, dq driven.
//  HOLD (1 cycle): oe_/we_=1, addr and cs held, write data still driven.
//   On read: data_out <= ram_dq, captured on the ACCESS->HOLD edge.
//  HOLD -> IDLE: cs1_=1, cs2=0, dq=Z, busy=0.
//  Total busy time: WAIT_CYCLES+2 cycles (4 at default).
//  data_out is valid when busy falls and holds until the next read completes.
//  ena ignored while busy; deasserting ena mid-access does not abort.
//  ena held high continuously: next request accepted on the first edge in IDLE.
//   This gives one busy-low cycle between back-to-back accesses.
//  oe_ and we_ are never low simultaneously. dq is never driven while oe_=0.
//  ram_addr holds its last value when idle.
// TESTING
//  Reset pulse mid-ACCESS of a write -> we_=1, cs1_=1, dq=Z, busy=0 immediately.
//  Idle, ena=1 write=0 addr=100 -> busy rises 1 edge later; ram_addr=100.
//   Then oe_ is low for exactly 2 cycles and busy stays high 4 cycles.
//  Write addr=0x1FFFF data=0xA5 -> we_ low 2 cycles with dq=0xA5 and cs1_=0/cs2=1.
//   dq stays driven for 1 cycle after we_ rises, then goes Z.
//  Read back 0x1FFFF from an SRAM model -> data_out=0xA5 when busy falls.
//  Drop ena 1 cycle after accept -> access still completes; busy returns 0 and stays 0.
//  Hold ena=1 across two accesses -> exactly one busy=0 cycle between them.
//   Check oe_ and we_ are never both low, throughout all scenarios.

Source files
------------

// File: rtl/sram_async_ctrl.sv
// Single-port sequencer for a 128K x 8 asynchronous SRAM (CS1_/CS2/OE_/WE_).
// Each accepted request runs SETUP -> ACCESS (WAIT_CYCLES) -> HOLD with registered pin outputs.
module sram_async_ctrl #(
  parameter int ADDR_W      = 17,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              write,
  input  logic              ena,
  output logic              busy,
  output logic [DATA_W-1:0] data_out,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] ram_dq,
  output logic              ram_we_,
  output logic              ram_oe_,
  output logic              ram_cs1_,
  output logic              ram_cs2
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_accept;
  logic              w_capture;
  logic              w_write_nxt;

  logic              r_write;
  logic [DATA_W-1:0] r_wdata;
  logic              r_dq_oe;
  logic              r_busy;
  logic [DATA_W-1:0] r_data_out;
  logic [ADDR_W-1:0] r_ram_addr;
  logic              r_we_;
  logic              r_oe_;
  logic              r_cs1_;
  logic              r_cs2;

  // Next-state, strobe-counter and accept/capture decode
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ena) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SETUP;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SETUP: begin
        w_state_nxt = S_ACCESS;
        w_cnt_nxt   = {CNT_W{1'b0}};
      end
      S_ACCESS: begin
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_HOLD;
          w_capture   = ~r_write;
        end else begin
          w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      S_HOLD:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    w_write_nxt = w_accept ? write : r_write;
  end

  // State and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= {CNT_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Pin outputs are decoded from the next state so they change on the same edge as the state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_write    <= 1'b0;
      r_wdata    <= {DATA_W{1'b0}};
      r_ram_addr <= {ADDR_W{1'b0}};
      r_data_out <= {DATA_W{1'b0}};
      r_busy     <= 1'b0;
      r_cs1_     <= 1'b1;
      r_cs2      <= 1'b0;
      r_oe_      <= 1'b1;
      r_we_      <= 1'b1;
      r_dq_oe    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write    <= write;
        r_wdata    <= data_in;
        r_ram_addr <= addr;
      end
      if (w_capture) begin
        r_data_out <= ram_dq;
      end
      r_busy  <= (w_state_nxt != S_IDLE);
      r_cs1_  <= (w_state_nxt == S_IDLE);
      r_cs2   <= (w_state_nxt != S_IDLE);
      r_oe_   <= ~((w_state_nxt == S_ACCESS) && ~w_write_nxt);
      r_we_   <= ~((w_state_nxt == S_ACCESS) && w_write_nxt);
      r_dq_oe <= (w_state_nxt != S_IDLE) && w_write_nxt;
    end
  end

  assign busy     = r_busy;
  assign data_out = r_data_out;
  assign ram_addr = r_ram_addr;
  assign ram_we_  = r_we_;
  assign ram_oe_  = r_oe_;
  assign ram_cs1_ = r_cs1_;
  assign ram_cs2  = r_cs2;
  assign ram_dq   = r_dq_oe ? r_wdata : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_async_ctrl.sv
// Bench for sram_async_ctrl: an async SRAM model on the pins plus a reference memory
// holding what the user side has written, checked by per-scenario tasks.
module tb_sram_async_ctrl;

  localparam int WAIT = 2;

  logic        clk;
  logic        reset;
  logic [16:0] addr;
  logic [7:0]  data_in;
  logic        write;
  logic        ena;
  logic        busy;
  logic [7:0]  data_out;
  logic [16:0] ram_addr;
  wire  [7:0]  ram_dq;
  logic        ram_we_;
  logic        ram_oe_;
  logic        ram_cs1_;
  logic        ram_cs2;

  int checks;
  int errors;

  logic [7:0] sram_mem [0:131071];
  logic [7:0] ref_mem [int];
  logic [7:0] last_rd;

  sram_async_ctrl #(.ADDR_W(17), .DATA_W(8), .WAIT_CYCLES(WAIT)) dut (
    .clk(clk), .reset(reset), .addr(addr), .data_in(data_in), .write(write),
    .ena(ena), .busy(busy), .data_out(data_out), .ram_addr(ram_addr),
    .ram_dq(ram_dq), .ram_we_(ram_we_), .ram_oe_(ram_oe_),
    .ram_cs1_(ram_cs1_), .ram_cs2(ram_cs2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Asynchronous SRAM: drives on CS+OE, latches data at the end of the WE pulse
  wire sram_drive = !ram_cs1_ && ram_cs2 && !ram_oe_ && ram_we_;
  assign ram_dq = sram_drive ? sram_mem[ram_addr] : 8'hzz;

  always @(posedge ram_we_) begin
    if (!reset && !ram_cs1_ && ram_cs2) sram_mem[ram_addr] = ram_dq;
  end

  // oe_ and we_ must never be low together, in any scenario
  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if (!ram_oe_ && !ram_we_) begin
        errors++;
        $display("FAIL strobe_overlap at %0t: oe_=%b we_=%b required not both 0", $time, ram_oe_, ram_we_);
      end
    end
  end

  function automatic logic [7:0] exp_rd(input logic [16:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    else return a[7:0] ^ 8'h3C;
  endfunction

  // Issues one request, drops ena once accepted, and measures the pin behaviour
  task automatic run_access(input logic w, input logic [16:0] a, input logic [7:0] d,
                            output int nb, output int noe, output int nwe_ok,
                            output int nhold, output logic [16:0] a_seen);
    bit started;
    bit prev_we;
    @(posedge clk); #1;
    ena = 1'b1; write = w; addr = a; data_in = d;
    nb = 0; noe = 0; nwe_ok = 0; nhold = 0; a_seen = '0;
    started = 1'b0; prev_we = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (busy && !started) begin
        started = 1'b1;
        a_seen = ram_addr;
        ena = 1'b0;
        addr = ~a;
        data_in = ~d;
      end
      if (busy) nb++;
      if (!ram_oe_) noe++;
      if (!ram_we_ && ram_dq == d && !ram_cs1_ && ram_cs2) nwe_ok++;
      if (!ram_we_ && !(ram_dq == d && !ram_cs1_ && ram_cs2)) nwe_ok--;
      if (busy && ram_we_ && !prev_we && ram_dq == d && !ram_cs1_) nhold++;
      prev_we = ram_we_;
      if (started && !busy) break;
    end
    if (w) ref_mem[int'(a)] = d;
    else last_rd = exp_rd(a);
  endtask

  task automatic test_reset();
    checks++;
    if (busy !== 1'b0 || data_out !== 8'h00 || ram_addr !== 17'h0 || ram_we_ !== 1'b1 ||
        ram_oe_ !== 1'b1 || ram_cs1_ !== 1'b1 || ram_cs2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%b dout=%h addr=%h we_=%b oe_=%b cs1_=%b cs2=%b required 0 00 0 1 1 1 0",
               busy, data_out, ram_addr, ram_we_, ram_oe_, ram_cs1_, ram_cs2);
    end
  endtask

  task automatic test_read_basic();
    int nb, noe, nwe, nh; logic [16:0] as;
    run_access(1'b0, 17'd100, 8'h00, nb, noe, nwe, nh, as);
    checks++;
    if (as !== 17'd100) begin errors++; $display("FAIL read_addr: got %h required %h", as, 17'd100); end
    checks++;
    if (noe !== WAIT) begin errors++; $display("FAIL read_oe_len: got %0d required %0d", noe, WAIT); end
    checks++;
    if (nb !== WAIT + 2) begin errors++; $display("FAIL read_busy_len: got %0d required %0d", nb, WAIT + 2); end
    checks++;
    if (data_out !== last_rd) begin errors++; $display("FAIL read_data: got %h required %h", data_out, last_rd); end
  endtask

  task automatic test_write_boundary();
    int nb, noe, nwe, nh; logic [16:0] as;
    run_access(1'b1, 17'h1FFFF, 8'hA5, nb, noe, nwe, nh, as);
    checks++;
    if (nwe !== WAIT) begin errors++; $display("FAIL write_we_dq: got %0d required %0d", nwe, WAIT); end
    checks++;
    if (nh !== 1) begin errors++; $display("FAIL write_hold_dq: got %0d required 1", nh); end
    checks++;
    if (noe !== 0 || nb !== WAIT + 2) begin
      errors++; $display("FAIL write_len: oe_low=%0d busy=%0d required 0 %0d", noe, nb, WAIT + 2);
    end
    checks++;
    if (data_out !== last_rd) begin errors++; $display("FAIL write_keeps_dout: got %h required %h", data_out, last_rd); end
  endtask

  task automatic test_readback();
    int nb, noe, nwe, nh; logic [16:0] as;
    run_access(1'b0, 17'h1FFFF, 8'h00, nb, noe, nwe, nh, as);
    checks++;
    if (data_out !== 8'hA5) begin errors++; $display("FAIL readback: got %h required a5", data_out); end
  endtask

  task automatic test_drop_ena();
    int nb, noe, nwe, nh, stray; logic [16:0] as;
    run_access(1'b0, 17'h00ABC, 8'h00, nb, noe, nwe, nh, as);
    stray = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (busy) stray++;
    end
    checks++;
    if (nb !== WAIT + 2 || stray !== 0) begin
      errors++; $display("FAIL drop_ena: busy_len=%0d later_busy=%0d required %0d 0", nb, stray, WAIT + 2);
    end
    checks++;
    if (data_out !== last_rd) begin errors++; $display("FAIL drop_ena_data: got %h required %h", data_out, last_rd); end
  endtask

  task automatic test_back_to_back();
    int rises, run1, gap, run2;
    bit prev, b;
    @(posedge clk); #1;
    ena = 1'b1; write = 1'b0; addr = 17'h1FFFF;
    rises = 0; run1 = 0; gap = 0; run2 = 0; prev = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      b = busy;
      if (b && !prev) begin
        rises++;
        if (rises == 1) addr = 17'd100;
        if (rises == 2) ena = 1'b0;
      end
      if (rises == 1 && b) run1++;
      if (rises == 1 && !b) gap++;
      if (rises == 2 && b) run2++;
      if (rises == 2 && !b) break;
      prev = b;
    end
    ena = 1'b0;
    last_rd = exp_rd(17'd100);
    checks++;
    if (run1 !== WAIT + 2 || gap !== 1 || run2 !== WAIT + 2) begin
      errors++; $display("FAIL back_to_back: run1=%0d gap=%0d run2=%0d required %0d 1 %0d", run1, gap, run2, WAIT + 2, WAIT + 2);
    end
    checks++;
    if (data_out !== last_rd) begin errors++; $display("FAIL back_to_back_data: got %h required %h", data_out, last_rd); end
  endtask

  task automatic test_random();
    int nb, noe, nwe, nh; logic [16:0] as, a; logic [7:0] d; logic w;
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom_range(0, 1));
      a = 17'h01000 + 17'($urandom_range(0, 7));
      d = 8'($urandom);
      run_access(w, a, d, nb, noe, nwe, nh, as);
      checks++;
      if (as !== a || nb !== WAIT + 2) begin
        errors++; $display("FAIL rand_addr_busy[%0d]: addr=%h busy=%0d required %h %0d", i, as, nb, a, WAIT + 2);
      end
      checks++;
      if (data_out !== last_rd) begin errors++; $display("FAIL rand_data[%0d]: got %h required %h", i, data_out, last_rd); end
      checks++;
      if (w ? (nwe !== WAIT || noe !== 0) : (noe !== WAIT || nwe !== 0)) begin
        errors++; $display("FAIL rand_strobes[%0d] w=%b: oe_low=%0d we_ok=%0d required %0d", i, w, noe, nwe, WAIT);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    bit seen;
    @(posedge clk); #1;
    ena = 1'b1; write = 1'b1; addr = 17'h00005; data_in = 8'h5A;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (busy) ena = 1'b0;
      if (!ram_we_) seen = 1'b1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL mid_write_we: got we_=%b required 0 before reset", ram_we_); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (ram_we_ !== 1'b1 || ram_cs1_ !== 1'b1 || ram_cs2 !== 1'b0 || busy !== 1'b0 || data_out !== 8'h00) begin
      errors++; $display("FAIL mid_write_reset: we_=%b cs1_=%b cs2=%b busy=%b dout=%h required 1 1 0 0 00",
                         ram_we_, ram_cs1_, ram_cs2, busy, data_out);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ram_we_ !== 1'b1) begin
      errors++; $display("FAIL after_reset_idle: busy=%b we_=%b required 0 1", busy, ram_we_);
    end
  endtask

  initial begin
    checks = 0; errors = 0; last_rd = 8'h00;
    for (int i = 0; i < 131072; i++) sram_mem[i] = 8'(i) ^ 8'h3C;
    reset = 1'b1; ena = 1'b0; write = 1'b0; addr = '0; data_in = '0;
    #3;
    test_reset();
    @(negedge clk);
    reset = 1'b0;
    test_read_basic();
    test_write_boundary();
    test_readback();
    test_drop_ena();
    test_back_to_back();
    test_random();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
